// File: rtl/mem_arbiter.sv
// Arbitrates the single-port word RAM between instruction fetch (I) and load/store (D).
// One access per cycle; responses return one cycle after grant, tagged by side.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [WORD_W-1:0]     i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [WORD_W-1:0]     d_wdata,
  input  logic [3:0]            d_wstrb,
  input  logic                  d_lock,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WORD_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [WORD_W-1:0]     mem_rdata
);

  typedef enum logic {ARB, OWN_D} state_t;

  state_t r_state, w_state_nxt;
  logic   r_rr_i, w_rr_nxt;          // 1: I wins the next contention
  logic   r_tag_vld, r_tag_d, r_tag_err, r_tag_rd;

  logic w_i_oor, w_d_oor, w_i_err, w_d_err, w_strb_ok, w_d_nop, w_mem_go, w_rsp;
  logic [1:0] w_d_off;

  assign w_i_oor = |i_addr[ADDR_W-1:DEPTH_LOG2+2];
  assign w_d_oor = |d_addr[ADDR_W-1:DEPTH_LOG2+2];
  assign w_d_off = d_addr[1:0];
  assign w_i_err = w_i_oor | (i_addr[1:0] != 2'b00);

  // Store strobes must be a byte, aligned half or full word matching the byte offset.
  always_comb begin
    w_strb_ok = 1'b0;
    case (d_wstrb)
      4'b0000: w_strb_ok = 1'b1;
      4'b0001: w_strb_ok = (w_d_off == 2'd0);
      4'b0010: w_strb_ok = (w_d_off == 2'd1);
      4'b0100: w_strb_ok = (w_d_off == 2'd2);
      4'b1000: w_strb_ok = (w_d_off == 2'd3);
      4'b0011: w_strb_ok = (w_d_off == 2'd0);
      4'b1100: w_strb_ok = (w_d_off == 2'd2);
      4'b1111: w_strb_ok = (w_d_off == 2'd0);
      default: w_strb_ok = 1'b0;
    endcase
  end

  assign w_d_err = w_d_oor | (d_we ? !w_strb_ok : (w_d_off != 2'd0));
  assign w_d_nop = d_we & (d_wstrb == 4'b0000);

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_i;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    if (!rst) begin
      case (r_state)
        ARB: begin
          if (i_req && d_req) begin
            i_gnt    = r_rr_i;
            d_gnt    = !r_rr_i;
            w_rr_nxt = !r_rr_i;
          end else begin
            i_gnt = i_req;
            d_gnt = d_req;
          end
          if (d_gnt && d_lock) w_state_nxt = OWN_D;
        end
        OWN_D: begin
          d_gnt = d_req;
          if (!d_req || !d_lock) w_state_nxt = ARB;
        end
        default: w_state_nxt = ARB;
      endcase
    end
  end

  // Erroring requests and empty stores are granted but never touch the RAM.
  assign w_mem_go  = (i_gnt & !w_i_err) | (d_gnt & !w_d_err & !w_d_nop);
  assign mem_en    = w_mem_go;
  assign mem_we    = w_mem_go & d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr[DEPTH_LOG2+1:2] :
                     i_gnt ? i_addr[DEPTH_LOG2+1:2] : '0;
  assign mem_wdata = (d_gnt && d_we) ? d_wdata : '0;
  assign mem_wstrb = (d_gnt && d_we) ? d_wstrb : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB;
      r_rr_i    <= 1'b0;
      r_tag_vld <= 1'b0;
      r_tag_d   <= 1'b0;
      r_tag_err <= 1'b0;
      r_tag_rd  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_i    <= w_rr_nxt;
      r_tag_vld <= i_gnt | d_gnt;
      r_tag_d   <= d_gnt;
      r_tag_err <= d_gnt ? w_d_err : (i_gnt & w_i_err);
      r_tag_rd  <= d_gnt ? (!d_we & !w_d_err) : (i_gnt & !w_i_err);
    end
  end

  // Masking with rst drops a response whose grant is followed directly by reset.
  assign w_rsp    = r_tag_vld & !rst;
  assign i_rvalid = w_rsp & !r_tag_d;
  assign d_rvalid = w_rsp & r_tag_d;
  assign i_err    = i_rvalid & r_tag_err;
  assign d_err    = d_rvalid & r_tag_err;
  assign i_rdata  = (i_rvalid && r_tag_rd) ? mem_rdata : '0;
  assign d_rdata  = (d_rvalid && r_tag_rd) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, expected responses queued at grant time and
// matched against per-cycle response observations.
module tb_mem_arbiter;
  localparam int AW = 32, DL = 10, WW = 32, MAXC = 512;

  logic          clk = 1'b0, rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [WW-1:0] d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic          i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_en, mem_we;
  logic [WW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [WW-1:0] ram_q = '0;
  logic [DL-1:0] mem_addr;
  logic [3:0]    mem_wstrb;

  mem_arbiter #(.ADDR_W(AW), .DEPTH_LOG2(DL), .WORD_W(WW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(ram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int k);
    return 32'h1000_0000 + 32'(k) * 32'h0001_0003;
  endfunction

  logic [31:0] ram [0:1023];
  logic [31:0] ref_mem [0:1023];

  // RAM model, reloaded with a known pattern during every reset cycle
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 1024; k++) ram[k] <= init_val(k);
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  obs_st [0:MAXC-1];
  logic [63:0] obs_d  [0:MAXC-1];
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      obs_st[cyc] <= {i_rvalid, d_rvalid, i_err, d_err};
      obs_d[cyc]  <= {i_rdata, d_rdata};
    end
  end

  typedef struct { int cyc; bit side_d; bit err; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int n_assert = 0, n_fail = 0;

  task automatic push(input bit sd, input bit e, input logic [31:0] dat);
    exp_t x;
    x.cyc = cyc + 1; x.side_d = sd; x.err = e; x.data = dat;
    sb.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wstrb = '0; d_lock = 0;
  endtask

  task automatic ref_init;
    for (int k = 0; k < 1024; k++) ref_mem[k] = init_val(k);
  endtask

  task automatic do_reset;
    idle; rst = 1; ref_init;
    tick; tick;
    rst = 0;
  endtask

  task automatic test_reset;
    tick;
    rst = 1; ref_init;
    i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 1; d_addr = 32'h20;
    d_wdata = 32'h5555_AAAA; d_wstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_assert++;
      if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_gnt: got %b exp 0000", {i_gnt, d_gnt, mem_en, mem_we});
      end
      n_assert++;
      if ({mem_addr, mem_wdata, mem_wstrb} !== '0) begin
        n_fail++; $display("FAIL reset_mem: got addr=%h wdata=%h wstrb=%b exp 0", mem_addr, mem_wdata, mem_wstrb);
      end
      tick;
    end
    rst = 0; idle;
  endtask

  task automatic test_i_only;
    logic [31:0] addrs [2];
    logic [9:0]  idx [2];
    addrs[0] = 32'h10;  idx[0] = 10'd4;
    addrs[1] = 32'hFFC; idx[1] = 10'd1023;
    for (int k = 0; k < 2; k++) begin
      i_req = 1; i_addr = addrs[k];
      @(negedge clk);
      n_assert++;
      if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b1010) begin
        n_fail++; $display("FAIL i_only_gnt[%0d]: got %b exp 1010", k, {i_gnt, d_gnt, mem_en, mem_we});
      end
      n_assert++;
      if (mem_addr !== idx[k]) begin
        n_fail++; $display("FAIL i_only_addr[%0d]: got %0d exp %0d", k, mem_addr, idx[k]);
      end
      push(0, 0, ref_mem[idx[k]]);
      tick;
    end
    idle; tick;
  endtask

  task automatic test_contention;
    bit ed;
    do_reset;
    i_req = 1; i_addr = 32'h30; d_req = 1; d_we = 0; d_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      ed = (k % 2 == 0);
      @(negedge clk);
      n_assert++;
      if ({i_gnt, d_gnt} !== {!ed, ed}) begin
        n_fail++; $display("FAIL contention_gnt[%0d]: got %b exp %b", k, {i_gnt, d_gnt}, {!ed, ed});
      end
      n_assert++;
      if (mem_addr !== (ed ? 10'd16 : 10'd12)) begin
        n_fail++; $display("FAIL contention_addr[%0d]: got %0d exp %0d", k, mem_addr, ed ? 16 : 12);
      end
      push(ed, 0, ed ? ref_mem[16] : ref_mem[12]);
      tick;
    end
    idle; tick;
  endtask

  task automatic test_store_load;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    @(negedge clk);
    n_assert++;
    if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b0111) begin
      n_fail++; $display("FAIL store_gnt: got %b exp 0111", {i_gnt, d_gnt, mem_en, mem_we});
    end
    n_assert++;
    if ({mem_addr, mem_wstrb, mem_wdata} !== {10'd8, 4'hF, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL store_cmd: got addr=%0d wstrb=%b wdata=%h exp 8 1111 deadbeef", mem_addr, mem_wstrb, mem_wdata);
    end
    push(1, 0, 32'h0); ref_mem[8] = 32'hDEAD_BEEF;
    tick;
    d_we = 0; d_wdata = '0; d_wstrb = '0;
    @(negedge clk);
    n_assert++;
    if ({d_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 10'd8}) begin
      n_fail++; $display("FAIL load_cmd: got %b addr=%0d exp 110 addr=8", {d_gnt, mem_en, mem_we}, mem_addr);
    end
    push(1, 0, ref_mem[8]);
    tick;
    d_we = 1; d_addr = 32'h21; d_wdata = 32'h0000_AB00; d_wstrb = 4'b0010;
    @(negedge clk);
    n_assert++;
    if ({mem_en, mem_we, mem_wstrb} !== 6'b11_0010) begin
      n_fail++; $display("FAIL byte_store: got %b exp 110010", {mem_en, mem_we, mem_wstrb});
    end
    push(1, 0, 32'h0); ref_mem[8][15:8] = 8'hAB;
    tick;
    d_addr = 32'h22; d_wdata = 32'h1234_0000; d_wstrb = 4'b1100;
    @(negedge clk);
    n_assert++;
    if ({mem_en, mem_we, mem_wstrb} !== 6'b11_1100) begin
      n_fail++; $display("FAIL half_store: got %b exp 111100", {mem_en, mem_we, mem_wstrb});
    end
    push(1, 0, 32'h0); ref_mem[8][31:16] = 16'h1234;
    tick;
    d_addr = 32'h20; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'b0000;
    @(negedge clk);
    n_assert++;
    if ({d_gnt, mem_en} !== 2'b10) begin
      n_fail++; $display("FAIL empty_store: got %b exp 10", {d_gnt, mem_en});
    end
    push(1, 0, 32'h0);
    tick;
    d_we = 0; d_wdata = '0;
    @(negedge clk);
    push(1, 0, ref_mem[8]);
    tick;
    idle; tick;
  endtask

  task automatic test_lock;
    do_reset;
    i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h44; d_lock = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) d_lock = 0;
      @(negedge clk);
      n_assert++;
      if ({i_gnt, d_gnt} !== 2'b01) begin
        n_fail++; $display("FAIL lock_gnt[%0d]: got %b exp 01", k, {i_gnt, d_gnt});
      end
      push(1, 0, ref_mem[17]);
      tick;
    end
    @(negedge clk);
    n_assert++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL unlock_gnt: got %b exp 10", {i_gnt, d_gnt});
    end
    push(0, 0, ref_mem[2]);
    tick;
    idle; tick;
  endtask

  task automatic test_errors;
    d_req = 1; d_we = 0; d_addr = 32'h22;
    @(negedge clk);
    n_assert++;
    if ({d_gnt, mem_en} !== 2'b10) begin
      n_fail++; $display("FAIL err_dmis: got %b exp 10", {d_gnt, mem_en});
    end
    push(1, 1, 32'h0);
    tick;
    idle; i_req = 1; i_addr = 32'h1000;
    @(negedge clk);
    n_assert++;
    if ({i_gnt, mem_en} !== 2'b10) begin
      n_fail++; $display("FAIL err_ioor: got %b exp 10", {i_gnt, mem_en});
    end
    push(0, 1, 32'h0);
    tick;
    i_addr = 32'h2;
    @(negedge clk);
    push(0, 1, 32'h0);
    tick;
    idle; d_req = 1; d_we = 1; d_addr = 32'h21; d_wdata = 32'h00FF_FF00; d_wstrb = 4'b0011;
    @(negedge clk);
    n_assert++;
    if ({d_gnt, mem_en, mem_we} !== 3'b100) begin
      n_fail++; $display("FAIL err_strb: got %b exp 100", {d_gnt, mem_en, mem_we});
    end
    push(1, 1, 32'h0);
    tick;
    d_addr = 32'h13; d_wdata = 32'hCC00_0000; d_wstrb = 4'b1000;
    @(negedge clk);
    n_assert++;
    if ({mem_en, mem_we, mem_addr} !== {2'b11, 10'd4}) begin
      n_fail++; $display("FAIL top_byte_store: got %b addr=%0d exp 11 addr=4", {mem_en, mem_we}, mem_addr);
    end
    push(1, 0, 32'h0); ref_mem[4][31:24] = 8'hCC;
    tick;
    d_we = 0; d_wstrb = '0; d_wdata = '0; d_addr = 32'h8000_0000;
    @(negedge clk);
    push(1, 1, 32'h0);
    tick;
    d_addr = 32'h10;
    @(negedge clk);
    push(1, 0, ref_mem[4]);
    tick;
    idle; tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    i_req = 1; i_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h8;
    @(negedge clk);
    n_assert++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_pre: got %b exp 01", {i_gnt, d_gnt});
    end
    tick;
    rst = 1; ref_init;
    @(negedge clk);
    n_assert++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en} !== 5'b0) begin
      n_fail++; $display("FAIL rstmid_drop: got %b exp 00000", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en});
    end
    tick;
    rst = 0; idle;
    @(negedge clk);
    n_assert++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, mem_en, mem_we, i_rdata, d_rdata,
         mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      n_fail++; $display("FAIL rstmid_idle: got nonzero outputs, exp all 0");
    end
    tick;
    i_req = 1; i_addr = 32'h4; d_req = 1; d_addr = 32'h8;
    @(negedge clk);
    n_assert++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_rr: got %b exp 01", {i_gnt, d_gnt});
    end
    push(1, 0, ref_mem[2]);
    tick;
    idle; tick;
  endtask

  task automatic test_responses;
    exp_t x;
    logic [3:0]  est;
    logic [63:0] edat;
    @(negedge clk); tick;
    for (int c = 0; c < cyc && c < MAXC; c++) begin
      est = 4'b0; edat = 64'h0;
      if (sb.size() > 0 && sb[0].cyc == c) begin
        x = sb.pop_front();
        est  = {!x.side_d, x.side_d, x.err & !x.side_d, x.err & x.side_d};
        edat = x.side_d ? {32'h0, x.data} : {x.data, 32'h0};
      end
      n_assert++;
      if ({obs_st[c], obs_d[c]} !== {est, edat}) begin
        n_fail++;
        $display("FAIL rsp cyc=%0d: got st=%b data=%h exp st=%b data=%h", c, obs_st[c], obs_d[c], est, edat);
      end
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL rsp_unmatched: got %0d left exp 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_i_only;
    test_contention;
    test_store_load;
    test_lock;
    test_errors;
    test_reset_mid;
    test_responses;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end

endmodule
